// File: rtl/fifo_ctrl_sync_wc_if.sv
// Producer, consumer and RAM-side signals of the width-converting FIFO controller.
// FIFO_ERR_FLAG_EN adds the sticky OVERFLOW/UNDERFLOW flags.
interface fifo_ctrl_sync_wc_if #(
  parameter int AWI = 5,
  parameter int AWO = 3,
  parameter int DWI = 4,
  parameter int DWO = 16
);
  localparam int AWN = (AWI > AWO) ? AWI : AWO;

  logic           WR_REQ;
  logic [DWI-1:0] WR_DATA;
  logic           FULL;
  logic           RD_REQ;
  logic [DWO-1:0] RD_DATA;
  logic           RD_VALID;
  logic           EMPTY;
  logic [AWN:0]   LEVEL;
  logic           RAM_WR_EN;
  logic [AWI-1:0] RAM_ADDR_WR;
  logic [DWI-1:0] RAM_D;
  logic           RAM_RD_EN;
  logic [AWO-1:0] RAM_ADDR_RD;
  logic [DWO-1:0] RAM_Q;
`ifdef FIFO_ERR_FLAG_EN
  logic           OVERFLOW;
  logic           UNDERFLOW;
`endif

  modport slave (
    input  WR_REQ, WR_DATA, RD_REQ, RAM_Q,
    output FULL, RD_DATA, RD_VALID, EMPTY, LEVEL,
    output RAM_WR_EN, RAM_ADDR_WR, RAM_D,
    output RAM_RD_EN, RAM_ADDR_RD
`ifdef FIFO_ERR_FLAG_EN
    , output OVERFLOW, UNDERFLOW
`endif
  );

  modport master (
    output WR_REQ, WR_DATA, RD_REQ, RAM_Q,
    input  FULL, RD_DATA, RD_VALID, EMPTY, LEVEL,
    input  RAM_WR_EN, RAM_ADDR_WR, RAM_D,
    input  RAM_RD_EN, RAM_ADDR_RD
`ifdef FIFO_ERR_FLAG_EN
    , input OVERFLOW, UNDERFLOW
`endif
  );
endinterface

// File: rtl/fifo_ctrl_sync_wc.sv
// Single-clock FIFO controller for an external width-converting dual-port RAM.
// Optional sticky error flags are enabled with FIFO_ERR_FLAG_EN.
module fifo_ctrl_sync_wc #(
  parameter int AWI = 5,
  parameter int AWO = 3,
  parameter int DWI = 4,
  parameter int DWO = 16
) (
  input logic                 CLK,
  input logic                 RST_N,
  fifo_ctrl_sync_wc_if.slave  bus
);
  localparam int N       = (DWI < DWO) ? DWI : DWO;
  localparam int AWN     = (AWI > AWO) ? AWI : AWO;
  localparam int DEPTH_N = 1 << AWN;
  localparam int WU      = DWI / N;
  localparam int RU      = DWO / N;
  localparam int LW      = AWN + 1;

  localparam logic [LW-1:0] WU_L  = LW'(WU);
  localparam logic [LW-1:0] RU_L  = LW'(RU);
  localparam logic [LW:0]   WU_X  = (LW+1)'(WU);
  localparam logic [LW:0]   DEP_X = (LW+1)'(DEPTH_N);

  logic [AWI:0]  wptr;
  logic [AWO:0]  rptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nx;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          wr_ok;
  logic          rd_ok;

  // Flags come only from the registered level, never from the requests.
  assign full  = ({1'b0, level} + WU_X) > DEP_X;
  assign empty = level < RU_L;

  assign wr_ok = bus.WR_REQ & ~full;
  assign rd_ok = bus.RD_REQ & ~empty;

  always_comb begin
    level_nx = level;
    if (wr_ok) level_nx = level_nx + WU_L;
    if (rd_ok) level_nx = level_nx - RU_L;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      level    <= level_nx;
      rd_valid <= rd_ok;
    end
  end

  assign bus.FULL        = full;
  assign bus.EMPTY       = empty;
  assign bus.LEVEL       = level;
  assign bus.RD_VALID    = rd_valid;
  assign bus.RD_DATA     = bus.RAM_Q;
  assign bus.RAM_WR_EN   = wr_ok;
  assign bus.RAM_ADDR_WR = wptr[AWI-1:0];
  assign bus.RAM_D       = bus.WR_DATA;
  assign bus.RAM_RD_EN   = rd_ok;
  assign bus.RAM_ADDR_RD = rptr[AWO-1:0];

`ifdef FIFO_ERR_FLAG_EN
  logic ovf;
  logic udf;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (bus.WR_REQ & full)  ovf <= 1'b1;
      if (bus.RD_REQ & empty) udf <= 1'b1;
    end
  end

  assign bus.OVERFLOW  = ovf;
  assign bus.UNDERFLOW = udf;
`endif
endmodule
